// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop bank.
package tff_pkg;

    localparam logic TFF_RESET_BIT = 1'b0;

    typedef enum logic {
        HOLD   = 1'b0,
        TOGGLE = 1'b1
    } tff_mode_e;

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with asynchronous active-high reset.
module tff_cell
    import tff_pkg::*;
#(
    parameter logic RESET_VALUE = TFF_RESET_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic state_q;
    logic state_d;

    // XOR keeps X on t propagating into the state.
    always_comb begin
        state_d = state_q ^ t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/t_ff.sv
// Bank of independent T flip-flops with complementary outputs.
module t_ff
    import tff_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{TFF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    if (WIDTH < 1) begin : g_bad_width
        $error("t_ff: WIDTH must be at least 1");
    end

    if ($bits(RESET_VALUE) != WIDTH) begin : g_bad_reset
        $error("t_ff: RESET_VALUE width must equal WIDTH");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .t  (t[i]),
            .q  (q[i])
        );
    end

    // qbar is never registered so it cannot disagree with q.
    assign qbar = ~q;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff: default single bit and a 4-bit bank.
module tb_t_ff;
    import tff_pkg::*;

    logic       clk;
    logic       rst;
    logic       t;
    logic       q;
    logic       qbar;
    logic [3:0] t4;
    logic [3:0] q4;
    logic [3:0] qbar4;

    int vectors;
    int miscompares;

    logic m;
    logic tv;

    t_ff dut (
        .clk (clk),
        .rst (rst),
        .t   (t),
        .q   (q),
        .qbar(qbar)
    );

    t_ff #(
        .WIDTH      (4),
        .RESET_VALUE(4'b1010)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .t   (t4),
        .q   (q4),
        .qbar(qbar4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        t   = HOLD;
        t4  = 4'b0000;
        repeat (2) tick();
        chk("reset_q", {3'b0, q}, 4'h0);
        chk("reset_qbar", {3'b0, qbar}, 4'h1);
        chk("reset_q4", q4, 4'b1010);
        chk("reset_qbar4", qbar4, 4'b0101);

        rst = 1'b0;
        t   = TOGGLE;
        t4  = 4'b0110;
        tick();
        chk("first_toggle_q", {3'b0, q}, 4'h1);
        chk("first_toggle_qbar", {3'b0, qbar}, 4'h0);
        chk("w4_q", q4, 4'b1100);
        chk("w4_qbar", qbar4, 4'b0011);
        t4 = 4'b0000;

        #3 rst = 1'b1;
        #1;
        chk("async_q", {3'b0, q}, 4'h0);
        chk("async_qbar", {3'b0, qbar}, 4'h1);
        chk("async_q4", q4, 4'b1010);
        repeat (3) begin
            tick();
            chk("rst_hold_q", {3'b0, q}, 4'h0);
            chk("rst_hold_qbar", {3'b0, qbar}, 4'h1);
        end

        rst = 1'b0;
        t   = HOLD;
        repeat (4) begin
            tick();
            chk("hold_q", {3'b0, q}, 4'h0);
            chk("hold_qbar", {3'b0, qbar}, 4'h1);
        end

        t = TOGGLE;
        m = 1'b0;
        repeat (4) begin
            tick();
            m = ~m;
            chk("toggle_q", {3'b0, q}, {3'b0, m});
            chk("toggle_qbar", {3'b0, qbar}, {3'b0, ~m});
        end

        for (int i = 0; i < 10; i++) begin
            t = 1'($urandom);
            tick();
            m = m ^ t;
            chk("rand_q", {3'b0, q}, {3'b0, m});
            chk("rand_qbar", {3'b0, qbar}, {3'b0, ~m});
        end

        #1 rst = 1'b1;
        t = 1'($urandom);
        #1;
        chk("pulse1_q", {3'b0, q}, 4'h0);
        #4 rst = 1'b0;
        #1;
        chk("pulse1_low_q", {3'b0, q}, 4'h0);
        tv = 1'($urandom);
        t  = tv;
        tick();
        chk("pulse_gap_q", {3'b0, q}, {3'b0, tv});
        #1 rst = 1'b1;
        #1;
        chk("pulse2_q", {3'b0, q}, 4'h0);
        t = TOGGLE;
        tick();
        chk("pulse2_edge_q", {3'b0, q}, 4'h0);
        chk("pulse2_edge_q4", q4, 4'b1010);

        @(posedge clk);
        rst <= 1'b0;
        #1;
        chk("coincident_release_q", {3'b0, q}, 4'h0);
        chk("coincident_release_qbar", {3'b0, qbar}, 4'h1);
        tick();
        chk("post_release_q", {3'b0, q}, 4'h1);
        chk("post_release_qbar", {3'b0, qbar}, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
